// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants for the multi-ported register file.
//   DEF_*    : default geometry for regfile_mp / regfile_rport
//   calc_aw  : address width for a power-of-two register count
// Optional feature macro used by the slice: REGFILE_BYPASS_EN (write->read
// forwarding inside regfile_rport).
package regfile_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_NREAD  = 2;
  localparam int DEF_NWRITE = 1;

  // A 2-entry file still needs one address bit.
  function automatic int calc_aw(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction
endpackage

// File: rtl/regfile_rport.sv
// regfile_rport -- one registered read port of regfile_mp.
//   clk, rst_n        : clock, synchronous active-low reset
//   stall             : hold rd_data/rd_busy
//   addr              : read address, sampled at the rising edge
//   regs, busy        : current storage and busy bits from the top
//   we/wr_addr/wr_data: this cycle's writes (used only for forwarding)
//   rsv_valid/rsv_addr: this cycle's reservation (used only for forwarding)
//   rd_data, rd_busy  : registered read result
// Macro REGFILE_BYPASS_EN: when defined, a read that collides with a write
// in the same cycle returns the post-update data/busy; otherwise pre-update.
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NREGS    = DEF_NREGS,
  parameter int NWRITE   = DEF_NWRITE,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic [AW-1:0]                  addr,
  input  logic [NREGS-1:0][WIDTH-1:0]    regs,
  input  logic [NREGS-1:0]               busy,
  input  logic [NWRITE-1:0]              we,
  input  logic [NWRITE-1:0][AW-1:0]      wr_addr,
  input  logic [NWRITE-1:0][WIDTH-1:0]   wr_data,
  input  logic                           rsv_valid,
  input  logic [AW-1:0]                  rsv_addr,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           rd_busy
);

  logic [WIDTH-1:0] data_d;
  logic             busy_d;

`ifndef REGFILE_BYPASS_EN
  // Write/reserve inputs only matter for forwarding.
  logic unused_fwd;
  assign unused_fwd = ^{we, wr_addr, wr_data, rsv_valid, rsv_addr};
`endif

  always_comb begin
    data_d = regs[addr];
    busy_d = busy[addr];
`ifdef REGFILE_BYPASS_EN
    // Ascending scan: the highest-index colliding writer ends up selected,
    // matching the storage priority. A reservation overrides the clear.
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j] && (wr_addr[j] == addr)) begin
        data_d = wr_data[j];
        busy_d = 1'b0;
      end
    end
    if (rsv_valid && (rsv_addr == addr)) busy_d = 1'b1;
`endif
    // Applied last so forwarding can never leak into register 0.
    if ((ZERO_REG != 0) && (addr == '0)) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else if (!stall) begin
      rd_data <= data_d;
      rd_busy <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-ported register file with per-register busy bits.
//   clk, rst_n         : clock, synchronous active-low reset
//   stall              : hold read outputs (writes/reservations still land)
//   rd_addr/rd_data    : NREAD registered read ports, 1-cycle latency
//   rd_busy            : registered busy bit of each addressed register
//   we/wr_addr/wr_data : NWRITE write ports, highest index wins on collision
//   rsv_valid/rsv_addr : mark a register pending-write (busy)
// Macro REGFILE_BYPASS_EN: enables same-cycle write->read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NREGS    = DEF_NREGS,
  parameter int NREAD    = DEF_NREAD,
  parameter int NWRITE   = DEF_NWRITE,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic [NREAD-1:0][AW-1:0]      rd_addr,
  output logic [NREAD-1:0][WIDTH-1:0]   rd_data,
  output logic [NREAD-1:0]              rd_busy,
  input  logic [NWRITE-1:0]             we,
  input  logic [NWRITE-1:0][AW-1:0]     wr_addr,
  input  logic [NWRITE-1:0][WIDTH-1:0]  wr_data,
  input  logic                          rsv_valid,
  input  logic [AW-1:0]                 rsv_addr
);

  logic [NREGS-1:0][WIDTH-1:0] regs_q;
  logic [NREGS-1:0]            busy_q;

  function automatic logic wr_ok(input logic [AW-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Later non-blocking assignments win: higher write ports override lower
  // ones, and a reservation overrides a same-cycle write's busy clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && wr_ok(wr_addr[j])) begin
          regs_q[wr_addr[j]] <= wr_data[j];
          busy_q[wr_addr[j]] <= 1'b0;
        end
      end
      if (rsv_valid && wr_ok(rsv_addr)) busy_q[rsv_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rport
    regfile_rport #(
      .WIDTH    (WIDTH),
      .NREGS    (NREGS),
      .NWRITE   (NWRITE),
      .ZERO_REG (ZERO_REG)
    ) u_rport (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .addr      (rd_addr[i]),
      .regs      (regs_q),
      .busy      (busy_q),
      .we        (we),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .rd_data   (rd_data[i]),
      .rd_busy   (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed + randomized bench for regfile_mp (2R/2W, 32x32).
// The reference model holds the architectural register/busy state; a read
// returns the state before this cycle's updates, or after them when
// REGFILE_BYPASS_EN is defined.
module tb_regfile_mp;
  localparam int W = 32;
  localparam int N = 32;
  localparam int A = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic [1:0][A-1:0] rd_addr;
  logic [1:0][W-1:0] rd_data;
  logic [1:0]        rd_busy;
  logic [1:0]        we;
  logic [1:0][A-1:0] wr_addr;
  logic [1:0][W-1:0] wr_data;
  logic              rsv_valid;
  logic [A-1:0]      rsv_addr;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] m_reg [N];
  bit           m_busy[N];
  logic [W-1:0] exp_data[2];
  logic         exp_busy[2];

  regfile_mp #(.WIDTH(W), .NREGS(N), .NREAD(2), .NWRITE(2), .ZERO_REG(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 2'b00; rsv_valid = 1'b0; stall = 1'b0;
    wr_addr = '0; wr_data = '0; rsv_addr = '0;
  endtask

  // One clock: evolve the model, advance the DUT, compare all read outputs.
  task automatic step();
    logic [W-1:0] n_reg [N];
    bit           n_busy[N];
    n_reg  = m_reg;
    n_busy = m_busy;
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin n_reg[r] = '0; n_busy[r] = 1'b0; end
      for (int i = 0; i < 2; i++) begin exp_data[i] = '0; exp_busy[i] = 1'b0; end
    end else begin
      for (int j = 0; j < 2; j++)
        if (we[j] && wr_addr[j] != 0) begin
          n_reg[wr_addr[j]]  = wr_data[j];
          n_busy[wr_addr[j]] = 1'b0;
        end
      if (rsv_valid && rsv_addr != 0) n_busy[rsv_addr] = 1'b1;
      if (!stall)
        for (int i = 0; i < 2; i++) begin
`ifdef REGFILE_BYPASS_EN
          exp_data[i] = n_reg[rd_addr[i]];
          exp_busy[i] = n_busy[rd_addr[i]];
`else
          exp_data[i] = m_reg[rd_addr[i]];
          exp_busy[i] = m_busy[rd_addr[i]];
`endif
        end
    end
    @(posedge clk); #1;
    m_reg  = n_reg;
    m_busy = n_busy;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_data%0d", i), rd_data[i], exp_data[i]);
      chk($sformatf("rd_busy%0d", i), {31'b0, rd_busy[i]}, {31'b0, exp_busy[i]});
    end
  endtask

  initial begin
    for (int r = 0; r < N; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
    exp_data[0] = '0; exp_data[1] = '0; exp_busy[0] = 1'b0; exp_busy[1] = 1'b0;
    idle();
    rd_addr = '0;
    rst_n = 1'b0;
    step(); step();
    chk("reset_data", rd_data[0], 32'h0);
    rst_n = 1'b1;

    // Fresh read after reset
    rd_addr[0] = 5; rd_addr[1] = 5;
    step();
    chk("r5_after_reset", rd_data[1], 32'h0);
    chk("r5_busy_after_reset", {31'b0, rd_busy[0]}, 32'h0);

    // Write r5 with same-cycle read, then a later read
    we[0] = 1'b1; wr_addr[0] = 5; wr_data[0] = 32'hDEADBEEF;
    step();
`ifdef REGFILE_BYPASS_EN
    chk("r5_same_cycle", rd_data[1], 32'hDEADBEEF);
`else
    chk("r5_same_cycle", rd_data[1], 32'h0);
`endif
    idle();
    step();
    chk("r5_next", rd_data[1], 32'hDEADBEEF);

    // Register 0 ignores writes and reservations
    we[0] = 1'b1; wr_addr[0] = 0; wr_data[0] = 32'h1234;
    rsv_valid = 1'b1; rsv_addr = 0; rd_addr[0] = 0; rd_addr[1] = 0;
    step();
    idle();
    step();
    chk("r0_data", rd_data[0], 32'h0);
    chk("r0_busy", {31'b0, rd_busy[1]}, 32'h0);

    // Dual-writer collision
    we = 2'b11; wr_addr[0] = 7; wr_addr[1] = 7;
    wr_data[0] = 32'h1111; wr_data[1] = 32'h2222;
    rd_addr[0] = 7; rd_addr[1] = 7;
    step();
    idle();
    step();
    chk("r7_collision", rd_data[0], 32'h2222);

    // Busy lifecycle on r3
    rd_addr[0] = 3; rd_addr[1] = 3;
    rsv_valid = 1'b1; rsv_addr = 3;
    step();
    idle();
    step();
    chk("r3_reserved", {31'b0, rd_busy[0]}, 32'h1);
    we[0] = 1'b1; wr_addr[0] = 3; wr_data[0] = 32'h55;
    step();
    idle();
    step();
    chk("r3_cleared", {31'b0, rd_busy[0]}, 32'h0);
    chk("r3_data", rd_data[1], 32'h55);
    we[1] = 1'b1; wr_addr[1] = 3; wr_data[1] = 32'h66;
    rsv_valid = 1'b1; rsv_addr = 3;
    step();
    idle();
    step();
    chk("r3_rsv_wins", {31'b0, rd_busy[1]}, 32'h1);
    chk("r3_data2", rd_data[0], 32'h66);

    // Stall hold on r9
    we[0] = 1'b1; wr_addr[0] = 9; wr_data[0] = 32'hA5;
    step();
    idle();
    rd_addr[0] = 9; rd_addr[1] = 9;
    step();
    chk("r9_loaded", rd_data[0], 32'hA5);
    stall = 1'b1; we[0] = 1'b1; wr_addr[0] = 9; wr_data[0] = 32'h5A;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("r9_held%0d", k), rd_data[1], 32'hA5);
    end
    idle();
    step();
    chk("r9_after_stall", rd_data[0], 32'h5A);

    // Reset during stall, with a pending reservation outstanding
    rsv_valid = 1'b1; rsv_addr = 9;
    step();
    idle();
    stall = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_stall", rd_data[0], 32'h0);
    rst_n = 1'b1; stall = 1'b0;
    step();
    chk("r9_after_rst_data", rd_data[0], 32'h0);
    chk("r9_after_rst_busy", {31'b0, rd_busy[1]}, 32'h0);

    // Randomized traffic over a narrow address window to force collisions
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      we        = 2'($urandom);
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_addr  = 5'($urandom_range(0, 7));
      for (int p = 0; p < 2; p++) begin
        wr_addr[p] = 5'($urandom_range(0, 7));
        wr_data[p] = $urandom;
        rd_addr[p] = 5'($urandom_range(0, 7));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
